// File: rtl/multiplier_datapath_taint_track_1bit_pkg.sv
// Shared types and constants for the shift-add multiplier and its taint tracking.
package multiplier_taint_pkg;

  localparam int unsigned START = 0;
  localparam int unsigned INIT  = 1;

  // Running sum is 2W product bits plus one carry bit above them.
  function automatic int unsigned rs_width(input int unsigned w);
    return 2 * w + 1;
  endfunction

  function automatic int unsigned final_state(input int unsigned w);
    return 2 * (w + 1);
  endfunction

  typedef struct packed {
    logic v;
    logic t;
  } strobe_pair_t;

  typedef struct packed {
    strobe_pair_t mdld;
    strobe_pair_t mrld;
    strobe_pair_t rsclear;
    strobe_pair_t rsload;
    strobe_pair_t rsshr;
  } ctrl_strobes_t;

endpackage

// File: rtl/multiplier_datapath_taint_track_1bit_if.sv
// Operand, strobe and result signals between the multiplier control and its datapath.
interface multiplier_datapath_taint_track_1bit_if #(
  parameter int unsigned WIDTH = 1024
);
  logic [WIDTH-1:0]   multiplicand_in;
  logic               multiplicand_in_t;
  logic [WIDTH-1:0]   multiplier_in;
  logic               multiplier_in_t;
  logic               mdld,        mdld_t;
  logic               mrld,        mrld_t;
  logic               rsclear,     rsclear_t;
  logic               rsload,      rsload_t;
  logic               rsshr,       rsshr_t;
  logic               productDone, productDone_t;
  logic [WIDTH-1:0]   multiplierReg;
  logic               multiplierReg_t;
  logic [2*WIDTH-1:0] product;
  logic               product_t;
  logic               product_valid, product_valid_t;

  modport master (
    output multiplicand_in, multiplicand_in_t, multiplier_in, multiplier_in_t,
    output mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
    output rsload, rsload_t, rsshr, rsshr_t, productDone, productDone_t,
    input  multiplierReg, multiplierReg_t, product, product_t,
    input  product_valid, product_valid_t
  );

  modport slave (
    input  multiplicand_in, multiplicand_in_t, multiplier_in, multiplier_in_t,
    input  mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
    input  rsload, rsload_t, rsshr, rsshr_t, productDone, productDone_t,
    output multiplierReg, multiplierReg_t, product, product_t,
    output product_valid, product_valid_t
  );
endinterface

// File: rtl/multiplier_datapath_taint_track_1bit_running_sum.sv
// Running-sum register with adder/shifter and its sticky taint bit.
module multiplier_running_sum_taint
  import multiplier_taint_pkg::*;
#(
  parameter int unsigned WIDTH = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  strobe_pair_t       clr,
  input  strobe_pair_t       ld,
  input  strobe_pair_t       shr,
  input  logic [WIDTH-1:0]   md,
  input  logic               md_t,
  output logic [2*WIDTH-1:0] product_q,
  output logic               rs_t_q,
  output logic               rs_t_next_c
);

  localparam int unsigned RSW = rs_width(WIDTH);

  logic [RSW-1:0] rs_q;
  logic [RSW-1:0] rs_next_c;
  logic [WIDTH:0] sum_c;
  logic           any_t_c;

  // Priority clear > add into upper half > shift right.
  always_comb begin
    rs_next_c = rs_q;
    sum_c     = {1'b0, rs_q[2*WIDTH-1:WIDTH]} + {1'b0, md};
    if (clr.v)      rs_next_c = '0;
    else if (ld.v)  rs_next_c[2*WIDTH:WIDTH] = sum_c;
    else if (shr.v) rs_next_c = rs_q >> 1;
  end

  // A tainted strobe taints RS even when its value is 0.
  always_comb begin
    any_t_c     = clr.t | ld.t | shr.t;
    rs_t_next_c = clr.v ? any_t_c : (rs_t_q | (ld.v & md_t) | any_t_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q   <= '0;
      rs_t_q <= 1'b0;
    end else begin
      rs_q   <= rs_next_c;
      rs_t_q <= rs_t_next_c;
    end
  end

  assign product_q = rs_q[2*WIDTH-1:0];

endmodule

// File: rtl/multiplier_datapath_taint_track_1bit.sv
// Shift-add multiplier datapath: MD/MR operand registers, running sum and product valid, all taint-shadowed.
module multiplier_datapath_taint_track_1bit
  import multiplier_taint_pkg::*;
#(
  parameter int unsigned WIDTH = 1024
) (
  input logic clk,
  input logic rst_n,
  multiplier_datapath_taint_track_1bit_if.slave bus
);

  ctrl_strobes_t      strb_c;
  logic [WIDTH-1:0]   md_q, mr_q;
  logic               md_t_q, mr_t_q;
  logic               valid_q, valid_t_q;
  logic [2*WIDTH-1:0] product_q;
  logic               rs_t_q, rs_t_next_c;

  always_comb begin
    strb_c         = '0;
    strb_c.mdld    = '{v: bus.mdld,    t: bus.mdld_t};
    strb_c.mrld    = '{v: bus.mrld,    t: bus.mrld_t};
    strb_c.rsclear = '{v: bus.rsclear, t: bus.rsclear_t};
    strb_c.rsload  = '{v: bus.rsload,  t: bus.rsload_t};
    strb_c.rsshr   = '{v: bus.rsshr,   t: bus.rsshr_t};
  end

  // Operand registers; taint clears only on a load whose own taint is clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_q   <= '0;
      mr_q   <= '0;
      md_t_q <= 1'b0;
      mr_t_q <= 1'b0;
    end else begin
      if (strb_c.mdld.v) md_q <= bus.multiplicand_in;
      if (strb_c.mrld.v) mr_q <= bus.multiplier_in;
      md_t_q <= strb_c.mdld.v ? (bus.multiplicand_in_t | strb_c.mdld.t) : (md_t_q | strb_c.mdld.t);
      mr_t_q <= strb_c.mrld.v ? (bus.multiplier_in_t | strb_c.mrld.t) : (mr_t_q | strb_c.mrld.t);
    end
  end

  multiplier_running_sum_taint #(.WIDTH(WIDTH)) u_rs (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (strb_c.rsclear),
    .ld          (strb_c.rsload),
    .shr         (strb_c.rsshr),
    .md          (md_q),
    .md_t        (md_t_q),
    .product_q   (product_q),
    .rs_t_q      (rs_t_q),
    .rs_t_next_c (rs_t_next_c)
  );

  // FINAL shift and productDone share an edge, so valid lines up with the final product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      valid_t_q <= 1'b0;
    end else begin
      valid_q   <= bus.productDone;
      valid_t_q <= bus.productDone_t | rs_t_next_c;
    end
  end

  assign bus.multiplierReg   = mr_q;
  assign bus.multiplierReg_t = mr_t_q;
  assign bus.product         = product_q;
  assign bus.product_t       = rs_t_q;
  assign bus.product_valid   = valid_q;
  assign bus.product_valid_t = valid_t_q;

endmodule

// File: tb/tb_multiplier_datapath_taint_track_1bit.sv
// Randomized self-checking bench acting as the multiplier control for a WIDTH=4 datapath.
module tb_multiplier_datapath_taint_track_1bit;
  import multiplier_taint_pkg::*;

  localparam int unsigned W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  multiplier_datapath_taint_track_1bit_if #(.WIDTH(W)) bus ();

  multiplier_datapath_taint_track_1bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.rsload && bus.rsshr))
        else $error("FAIL protocol: rsload and rsshr high together");
    end
  end

  task automatic idle();
    bus.multiplicand_in = '0; bus.multiplicand_in_t = 1'b0;
    bus.multiplier_in   = '0; bus.multiplier_in_t   = 1'b0;
    bus.mdld    = 1'b0; bus.mdld_t    = 1'b0;
    bus.mrld    = 1'b0; bus.mrld_t    = 1'b0;
    bus.rsclear = 1'b0; bus.rsclear_t = 1'b0;
    bus.rsload  = 1'b0; bus.rsload_t  = 1'b0;
    bus.rsshr   = 1'b0; bus.rsshr_t   = 1'b0;
    bus.productDone = 1'b0; bus.productDone_t = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as control: load+clear, shift on zero, then per bit optional add and shift.
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic a_t, input logic b_t);
    logic [2*W-1:0] a8, b8, exp_p;
    logic           exp_t;
    logic           first_add;
    a8 = (2*W)'(a);
    b8 = (2*W)'(b);
    exp_p = a8 * b8;
    exp_t = a_t && (b != '0);
    idle();
    bus.multiplicand_in = a; bus.multiplicand_in_t = a_t;
    bus.multiplier_in   = b; bus.multiplier_in_t   = b_t;
    bus.mdld = 1'b1; bus.mrld = 1'b1; bus.rsclear = 1'b1;
    tick();
    total++; if (bus.product_valid !== 1'b0) begin bad++; $display("FAIL valid_drop: got %b want 0", bus.product_valid); end
    total++; if (bus.multiplierReg !== b) begin bad++; $display("FAIL mr_load: got %0d want %0d", bus.multiplierReg, b); end
    total++; if (bus.multiplierReg_t !== b_t) begin bad++; $display("FAIL mr_taint: got %b want %b", bus.multiplierReg_t, b_t); end
    total++; if (bus.product !== '0 || bus.product_t !== 1'b0) begin bad++; $display("FAIL clear: got %0d/%b want 0/0", bus.product, bus.product_t); end
    idle(); bus.rsshr = 1'b1;
    tick();
    first_add = 1'b1;
    for (int i = 0; i < int'(W); i++) begin
      if (b[i]) begin
        idle(); bus.rsload = 1'b1;
        tick();
        if (first_add) begin
          total++; if (bus.product !== (a8 << W)) begin bad++; $display("FAIL first_add: got %0d want %0d", bus.product, a8 << W); end
          total++; if (bus.product_t !== a_t) begin bad++; $display("FAIL first_add_taint: got %b want %b", bus.product_t, a_t); end
          first_add = 1'b0;
        end
      end
      idle(); bus.rsshr = 1'b1; bus.productDone = (i == int'(W) - 1);
      tick();
    end
    idle();
    total++; if (bus.product !== exp_p) begin bad++; $display("FAIL product %0dx%0d: got %0d want %0d", a, b, bus.product, exp_p); end
    total++; if (bus.product_valid !== 1'b1) begin bad++; $display("FAIL valid_pulse: got %b want 1", bus.product_valid); end
    total++; if (bus.product_t !== exp_t) begin bad++; $display("FAIL product_t: got %b want %b", bus.product_t, exp_t); end
    total++; if (bus.product_valid_t !== exp_t) begin bad++; $display("FAIL valid_t: got %b want %b", bus.product_valid_t, exp_t); end
    total++; if (dut.u_rs.rs_q[2*W] !== 1'b0) begin bad++; $display("FAIL carry_bit: got %b want 0", dut.u_rs.rs_q[2*W]); end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++; if (bus.product !== '0 || bus.product_t !== 1'b0) begin bad++; $display("FAIL reset_product: got %0d/%b want 0/0", bus.product, bus.product_t); end
    total++; if (bus.product_valid !== 1'b0 || bus.product_valid_t !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b/%b want 0/0", bus.product_valid, bus.product_valid_t); end
    total++; if (bus.multiplierReg !== '0 || bus.multiplierReg_t !== 1'b0) begin bad++; $display("FAIL reset_mr: got %0d/%b want 0/0", bus.multiplierReg, bus.multiplierReg_t); end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_valid_ends();
    idle();
    tick();
    total++; if (bus.product_valid !== 1'b0) begin bad++; $display("FAIL valid_one_cycle: got %b want 0", bus.product_valid); end
  endtask

  task automatic test_strobe_taint();
    idle(); bus.rsclear = 1'b1;
    tick();
    idle(); bus.rsshr_t = 1'b1;
    tick();
    total++; if (bus.product_t !== 1'b1) begin bad++; $display("FAIL strobe_taint: got %b want 1", bus.product_t); end
    idle();
    for (int k = 0; k < 3; k++) tick();
    total++; if (bus.product_t !== 1'b1) begin bad++; $display("FAIL taint_sticky: got %b want 1", bus.product_t); end
    bus.rsclear = 1'b1;
    tick();
    idle();
    total++; if (bus.product_t !== 1'b0) begin bad++; $display("FAIL taint_clear: got %b want 0", bus.product_t); end
  endtask

  task automatic test_reset_mid();
    int unsigned shifts;
    logic [W-1:0] b;
    b = W'(11);
    shifts = 0;
    idle();
    bus.multiplicand_in = W'(13); bus.multiplier_in = b;
    bus.mdld = 1'b1; bus.mrld = 1'b1; bus.rsclear = 1'b1;
    tick();
    idle(); bus.rsshr = 1'b1; tick(); shifts++;
    for (int i = 0; i < int'(W) && shifts < 2; i++) begin
      if (b[i]) begin idle(); bus.rsload = 1'b1; tick(); end
      idle(); bus.rsshr = 1'b1; tick(); shifts++;
    end
    if (b[1]) begin idle(); bus.rsload = 1'b1; tick(); end
    idle(); bus.rsshr = 1'b1; bus.productDone = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.product !== '0 || bus.product_t !== 1'b0) begin bad++; $display("FAIL midreset_product: got %0d/%b want 0/0", bus.product, bus.product_t); end
    total++; if (bus.multiplierReg !== '0) begin bad++; $display("FAIL midreset_mr: got %0d want 0", bus.multiplierReg); end
    tick();
    idle();
    total++; if (bus.product_valid !== 1'b0 || bus.product_valid_t !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b/%b want 0/0", bus.product_valid, bus.product_valid_t); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    total++; if (bus.product_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", bus.product_valid); end
    run_mult(W'(6), W'(7), 1'b0, 1'b0);
    test_valid_ends();
  endtask

  task automatic test_back_to_back();
    run_mult(W'(0), W'(0), 1'b0, 1'b0);
    run_mult(W'(9), W'(9), 1'b0, 1'b0);
    test_valid_ends();
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_mult(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    test_valid_ends();
  endtask

  initial begin
    idle();
    test_reset();
    run_mult(W'(13), W'(11), 1'b0, 1'b0);
    test_valid_ends();
    run_mult(W'(15), W'(15), 1'b0, 1'b0);
    test_valid_ends();
    run_mult(W'(13), W'(11), 1'b1, 1'b0);
    test_valid_ends();
    test_strobe_taint();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
